// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Instruction-fetch control FSM for the 16-bit controller. Issues
//            memory reads for the opcode word and, for two-word instructions,
//            the immediate word. Pulses the ISR/immediate load strobes and the
//            PC increment, decodes halt / two-word opcodes, then hands the
//            instruction to the execute stage and waits for completion.
// Ports    : i_clk        system clock (rising edge)
//            i_clr        asynchronous active-high reset
//            i_run        run enable (level)
//            i_halt_req   halt request, latched, honoured at instr boundary
//            i_mem_rdy    read data valid on M_BUS this cycle
//            i_isr[15:0]  current instruction register contents
//            i_exec_done  execute unit finished current instruction
//            o_mas        memory address select = PC
//            o_mem_rd     memory read request
//            o_mis        load ISR from M_BUS (one cycle)
//            o_mim        load immediate register from M_BUS (one cycle)
//            o_pc_inc     increment PC (one cycle)
//            o_exec       execute phase active
//            o_halted     in HALT state
//            o_fault      bus timeout fault (sticky until i_clr)
//            o_state[2:0] current state encoding
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
  parameter int TIMEOUT = 15  // legal range 1..255
) (
  input  logic        i_clk,
  input  logic        i_clr,
  input  logic        i_run,
  input  logic        i_halt_req,
  input  logic        i_mem_rdy,
  input  logic [15:0] i_isr,
  input  logic        i_exec_done,
  output logic        o_mas,
  output logic        o_mem_rd,
  output logic        o_mis,
  output logic        o_mim,
  output logic        o_pc_inc,
  output logic        o_exec,
  output logic        o_halted,
  output logic        o_fault,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_FETCH_IMM = 3'd3,
    S_EXEC      = 3'd4,
    S_HALT      = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  // Wait count value seen during the TIMEOUT-th consecutive wait cycle.
  localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_wait;
  logic [7:0]  w_wait_nxt;
  logic        r_pend;
  logic        w_pend_now;
  logic        w_pend_nxt;
  logic        w_in_fetch;
  logic        w_timeout;
  logic        w_unused_isr;

  assign w_unused_isr = ^i_isr[11:0];

  assign w_in_fetch = (r_state == S_FETCH) || (r_state == S_FETCH_IMM);
  // The TIMEOUT-th fetch cycle faults even if data arrives in that cycle.
  assign w_timeout  = w_in_fetch && (r_wait == c_WAIT_LAST);
  // A halt request arriving this cycle counts as pending for this cycle's
  // decision, so it wins against a simultaneous EXEC_DONE.
  assign w_pend_now = r_pend ||
                      (i_halt_req && (r_state != S_HALT) && (r_state != S_FAULT));

  always_comb begin
    w_state_nxt = r_state;
    o_mas       = 1'b0;
    o_mem_rd    = 1'b0;
    o_mis       = 1'b0;
    o_mim       = 1'b0;
    o_pc_inc    = 1'b0;
    o_exec      = 1'b0;
    o_halted    = 1'b0;
    o_fault     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_run) w_state_nxt = w_pend_now ? S_HALT : S_FETCH;
      end
      S_FETCH, S_FETCH_IMM: begin
        o_mas    = 1'b1;
        o_mem_rd = 1'b1;
        if (w_timeout) begin
          w_state_nxt = S_FAULT;
        end else if (i_mem_rdy) begin
          o_pc_inc = 1'b1;
          if (r_state == S_FETCH) begin
            o_mis       = 1'b1;
            w_state_nxt = S_DECODE;
          end else begin
            o_mim       = 1'b1;
            w_state_nxt = S_EXEC;
          end
        end
      end
      S_DECODE: begin
        if (i_isr[15:12] == 4'hF)      w_state_nxt = S_HALT;
        else if (i_isr[15:12] == 4'h1) w_state_nxt = S_FETCH_IMM;
        else                           w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        o_exec = 1'b1;
        if (i_exec_done) begin
          if (w_pend_now)  w_state_nxt = S_HALT;
          else if (!i_run) w_state_nxt = S_IDLE;
          else             w_state_nxt = S_FETCH;
        end
      end
      S_HALT: begin
        o_halted = 1'b1;
        if (!i_run) w_state_nxt = S_IDLE;
      end
      S_FAULT: begin
        o_fault = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Counter is zero outside the fetch states, so entering a fetch state
  // always starts from zero; it only advances on wait cycles.
  always_comb begin
    w_wait_nxt = 8'd0;
    if (w_in_fetch && !w_timeout && !i_mem_rdy) w_wait_nxt = r_wait + 8'd1;
  end

  assign w_pend_nxt = (w_state_nxt == S_HALT) ? 1'b0 : w_pend_now;

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_state <= S_IDLE;
      r_wait  <= 8'd0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  assign o_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Self-checking bench for fetch_sequencer. Directed scenarios
//            followed by randomized traffic, every cycle compared against a
//            behavioural model of the instruction sequencing rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  localparam int TIMEOUT = 15;

  logic        clk;
  logic        clr;
  logic        run;
  logic        halt_req;
  logic        mem_rdy;
  logic [15:0] isr;
  logic        exec_done;
  logic        mas, mem_rd, mis, mim, pc_inc, exec_o, halted, fault;
  logic [2:0]  state;

  int errors = 0;
  int checks = 0;
  int cnt_mis, cnt_mim, cnt_pc, cnt_exec;

  // Behavioural model: phase number (spec encoding), wait cycles so far,
  // halt pending flag.
  int m_phase;
  int m_waits;
  bit m_pend;

  fetch_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_clr(clr), .i_run(run), .i_halt_req(halt_req),
    .i_mem_rdy(mem_rdy), .i_isr(isr), .i_exec_done(exec_done),
    .o_mas(mas), .o_mem_rd(mem_rd), .o_mis(mis), .o_mim(mim),
    .o_pc_inc(pc_inc), .o_exec(exec_o), .o_halted(halted), .o_fault(fault),
    .o_state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] observed();
    return {state, mas, mem_rd, mis, mim, pc_inc, exec_o, halted, fault};
  endfunction

  // Expected outputs for the current cycle from the model and live inputs.
  function automatic logic [10:0] expected();
    bit fetching, word_ok;
    fetching = (m_phase == 1) || (m_phase == 3);
    word_ok  = fetching && mem_rdy && (m_waits + 1 < TIMEOUT);
    return {3'(m_phase), fetching, fetching, word_ok && m_phase == 1,
            word_ok && m_phase == 3, word_ok, m_phase == 4, m_phase == 5,
            m_phase == 6};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_waits = 0;
    m_pend  = 0;
  endtask

  // Advance the model by one clock edge using the inputs held this cycle.
  task automatic model_edge();
    bit pend_now;
    int nxt;
    pend_now = m_pend || (halt_req && m_phase != 5 && m_phase != 6);
    nxt = m_phase;
    if (m_phase == 0) begin
      if (run) nxt = pend_now ? 5 : 1;
    end else if (m_phase == 1 || m_phase == 3) begin
      if (m_waits + 1 == TIMEOUT)  nxt = 6;
      else if (mem_rdy)            nxt = (m_phase == 1) ? 2 : 4;
    end else if (m_phase == 2) begin
      if (isr[15:12] == 4'hF)      nxt = 5;
      else if (isr[15:12] == 4'h1) nxt = 3;
      else                         nxt = 4;
    end else if (m_phase == 4) begin
      if (exec_done) nxt = pend_now ? 5 : (run ? 1 : 0);
    end else if (m_phase == 5) begin
      if (!run) nxt = 0;
    end
    if ((m_phase == 1 || m_phase == 3) && nxt == m_phase && !mem_rdy)
      m_waits = m_waits + 1;
    else
      m_waits = 0;
    m_pend  = (nxt == 5) ? 1'b0 : pend_now;
    m_phase = nxt;
  endtask

  // One cycle: inputs were set at the preceding negedge.
  task automatic cyc(input string tag);
    #1;
    check(tag, 32'(observed()), 32'(expected()));
    cnt_mis  += int'(mis);
    cnt_mim  += int'(mim);
    cnt_pc   += int'(pc_inc);
    cnt_exec += int'(exec_o);
    @(posedge clk);
    if (!clr) model_edge();
    @(negedge clk);
  endtask

  task automatic clear_counts();
    cnt_mis = 0; cnt_mim = 0; cnt_pc = 0; cnt_exec = 0;
  endtask

  // Asynchronous clear from mid-cycle; outputs must drop with no edge.
  task automatic clr_now(input string tag);
    #1;
    clr = 1'b1;
    #1;
    check({tag, "_async"}, 32'(observed()), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check({tag, "_held"}, 32'(observed()), 32'd0);
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic run_until(input int phase, input string tag);
    int guard;
    guard = 0;
    while (m_phase != phase && guard < 40) begin
      cyc(tag);
      guard++;
    end
    check({tag, "_reached"}, 32'(m_phase), 32'(phase));
  endtask

  int burst;

  initial begin
    clr = 1'b1; run = 0; halt_req = 0; mem_rdy = 0; isr = 16'h0000; exec_done = 0;
    model_reset();
    clear_counts();
    @(negedge clk);
    #1;
    check("reset_state", 32'(observed()), 32'd0);
    @(negedge clk);
    clr = 1'b0;

    // Single-word instructions back to back.
    run = 1; mem_rdy = 1; isr = 16'h2000; exec_done = 1;
    cyc("idle_start");
    clear_counts();
    for (int i = 0; i < 9; i++) cyc("single_word");
    check("single_mis_cnt", 32'(cnt_mis), 32'd3);
    check("single_pc_cnt", 32'(cnt_pc), 32'd3);

    // Two-word instructions.
    isr = 16'h1234;
    clear_counts();
    for (int i = 0; i < 8; i++) cyc("two_word");
    check("two_mis_cnt", 32'(cnt_mis), 32'd2);
    check("two_mim_cnt", 32'(cnt_mim), 32'd2);
    check("two_pc_cnt", 32'(cnt_pc), 32'd4);

    // Three wait cycles then data.
    isr = 16'h2000;
    clear_counts();
    mem_rdy = 0;
    for (int i = 0; i < 3; i++) cyc("wait3");
    check("wait3_still_fetch", 32'(state), 32'd1);
    mem_rdy = 1;
    cyc("wait3_data");
    check("wait3_mis_cnt", 32'(cnt_mis), 32'd1);
    cyc("wait3_decode");
    cyc("wait3_exec");

    // Timeout: TIMEOUT consecutive wait cycles.
    mem_rdy = 0;
    for (int i = 0; i < TIMEOUT; i++) cyc("timeout_wait");
    #1;
    check("timeout_fault", 32'({fault, state}), 32'({1'b1, 3'd6}));
    @(negedge clk);
    mem_rdy = 1; run = 1;
    for (int i = 0; i < 5; i++) cyc("fault_sticky");
    check("fault_still", 32'(fault), 32'd1);
    clr_now("clr_fault");

    // Data arriving in the TIMEOUT-th cycle is still rejected.
    run = 1; mem_rdy = 0; exec_done = 1;
    cyc("late_idle");
    for (int i = 0; i < TIMEOUT - 1; i++) cyc("late_wait");
    mem_rdy = 1;
    cyc("late_data");
    check("late_rejected", 32'(state), 32'd6);
    clr_now("clr_late");

    // Halt request pulse during fetch.
    run = 1; mem_rdy = 1; isr = 16'h2000; exec_done = 0;
    cyc("halt_idle");
    halt_req = 1;
    cyc("halt_req_fetch");
    halt_req = 0;
    cyc("halt_decode");
    cyc("halt_exec_wait");
    check("halt_not_yet", 32'(state), 32'd4);
    exec_done = 1;
    cyc("halt_exec_done");
    check("halt_entered", 32'({halted, state}), 32'({1'b1, 3'd5}));
    cyc("halt_stay");
    run = 0;
    cyc("halt_run_off");
    check("halt_to_idle", 32'(state), 32'd0);

    // Halt opcode.
    run = 1; isr = 16'hF000;
    clear_counts();
    run_until(5, "halt_opcode");
    check("halt_opcode_no_exec", 32'(cnt_exec), 32'd0);
    run = 0;
    cyc("halt_op_off");

    // Halt request together with EXEC_DONE, and with RUN low.
    run = 1; isr = 16'h2000; exec_done = 0;
    run_until(4, "hreq_done");
    halt_req = 1; exec_done = 1;
    cyc("hreq_done_same");
    halt_req = 0;
    check("hreq_done_halt", 32'(state), 32'd5);
    run = 0;
    cyc("hreq_off");
    run = 1; exec_done = 0;
    run_until(2, "pend_runoff");
    halt_req = 1;
    cyc("pend_set");
    halt_req = 0;
    run = 0; exec_done = 1;
    cyc("pend_runoff_done");
    check("pend_runoff_halt", 32'(state), 32'd5);
    cyc("pend_idle");

    // Clear mid-EXEC and mid-FETCH with data ready.
    run = 1; exec_done = 0; mem_rdy = 1;
    run_until(4, "clr_exec");
    clr_now("clr_mid_exec");
    cyc("restart_idle");
    check("restart_fetch", 32'(state), 32'd1);
    clr_now("clr_mid_fetch");
    exec_done = 1;
    clear_counts();
    for (int i = 0; i < 4; i++) cyc("restart");
    check("restart_mis_cnt", 32'(cnt_mis), 32'd1);

    // Randomized traffic.
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      run       = ($urandom_range(0, 9) != 0);
      halt_req  = ($urandom_range(0, 24) == 0);
      exec_done = $urandom_range(0, 1) == 1;
      if (burst == 0 && $urandom_range(0, 149) == 0) burst = $urandom_range(10, 18);
      if (burst > 0) begin
        mem_rdy = 0;
        burst--;
      end else begin
        mem_rdy = ($urandom_range(0, 2) != 0);
      end
      case ($urandom_range(0, 3))
        0: isr = {4'h1, 12'($urandom)};
        1: isr = {4'hF, 12'($urandom)};
        default: isr = 16'($urandom);
      endcase
      if ((m_phase == 6 && $urandom_range(0, 4) == 0) || $urandom_range(0, 199) == 0)
        clr_now("rand_clr");
      else
        cyc("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
